// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Truth table of sillyfunction: y = ~b&~c | a&~b  (rows 0, 4, 5 high).
  localparam logic [7:0] SILLY_TRUTH = 8'h31;

  localparam int NVEC  = 8;
  localparam int IDX_W = 3;

endpackage

// File: rtl/truth_table_sweeper.sv
// Sweeps abc through 000..111, lets the combinational block under test
// settle for SETTLE cycles per vector, samples y and scores it against EXPECT.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter logic [NVEC-1:0] EXPECT = SILLY_TRUTH,
  parameter int unsigned     SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             y,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       err_count,
  output logic             fail_valid,
  output logic [IDX_W-1:0] fail_idx
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0]       ERR_MAX     = 4'(NVEC);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NVEC - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_settle;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [3:0]       r_err;
  logic             r_fail_valid;
  logic [IDX_W-1:0] r_fail_idx;

  logic             w_mismatch;
  logic [3:0]       w_err_next;

  // Score the current vector; an X/Z on y is treated as wrong.
  always_comb begin
    w_mismatch = (y !== EXPECT[r_idx]);
    w_err_next = r_err;
    if (w_mismatch && (r_err != ERR_MAX)) begin
      w_err_next = r_err + 4'd1;
    end
  end

  // Sweep controller; every output comes straight from a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_settle     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state      <= DRIVE;
            r_idx        <= '0;
            r_settle     <= '0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        DRIVE: begin
          if (r_settle == SETTLE_LAST) begin
            r_state <= SAMPLE;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        SAMPLE: begin
          r_err <= w_err_next;
          if (w_mismatch && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_idx   <= r_idx;
          end
          if (r_idx == LAST_IDX) begin
            // Verdict uses the count including the last vector's result.
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 4'd0);
          end else begin
            r_idx    <= r_idx + 1'b1;
            r_settle <= '0;
            r_state  <= DRIVE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign a          = r_idx[2];
  assign b          = r_idx[1];
  assign c          = r_idx[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_valid = r_fail_valid;
  assign fail_idx   = r_fail_idx;

endmodule
